lr_shift_sweep: RTL and testbench

//   Sequencer directly upstream of the flat left-right shifter. Accepts one request (word + direction)
//   on a valid/ready port and drives the shifter's iBits/shift/dir inputs through shift = 0..width-1,
//   one amount per cycle. Captures each shifter result (oBits) into a registered valid/ready output

---
 rtl/lr_shift_sweep_if.sv | 35 +++
 rtl/lr_shift_sweep.sv | 94 +++++++++
 tb/tb_lr_shift_sweep.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lr_shift_sweep_if.sv
// Request, shifter-drive and result-stream signals of the shift-sweep sequencer.
// master is the surrounding logic, slave is the sequencer itself.
interface lr_shift_sweep_if #(
    parameter int width = 8
);
    localparam int sw = (width > 1) ? $clog2(width) : 1;

    logic             req_valid;
    logic             req_ready;
    logic [width-1:0] req_bits;
    logic             req_dir;

    logic [width-1:0] sh_bits;
    logic [sw-1:0]    sh_shift;
    logic             sh_dir;
    logic [width-1:0] sh_res;

    logic             out_valid;
    logic             out_ready;
    logic [width-1:0] out_bits;
    logic [sw-1:0]    out_shift;
    logic             out_last;

    modport master (
        output req_valid, req_bits, req_dir, sh_res, out_ready,
        input  req_ready, sh_bits, sh_shift, sh_dir,
        input  out_valid, out_bits, out_shift, out_last
    );

    modport slave (
        input  req_valid, req_bits, req_dir, sh_res, out_ready,
        output req_ready, sh_bits, sh_shift, sh_dir,
        output out_valid, out_bits, out_shift, out_last
    );
endinterface

// File: rtl/lr_shift_sweep.sv
// Drives a flat left/right shifter through shift 0..width-1 for one request
// and streams each result out through a registered valid/ready stage.
module lr_shift_sweep #(
    parameter int width = 8
) (
    input logic            clk,
    input logic            rst,
    lr_shift_sweep_if.slave bus
);
    localparam int sw = (width > 1) ? $clog2(width) : 1;
    localparam logic [sw-1:0] cnt_last = sw'(width - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t        state, state_d;
    logic [sw-1:0] cnt, cnt_d;
    logic          accept;
    logic          capture;
    logic          slot_free;
    logic          at_last;

    assign slot_free    = !bus.out_valid || bus.out_ready;
    assign at_last      = (cnt == cnt_last);
    assign bus.req_ready = (state == IDLE);
    assign bus.sh_shift  = cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        accept  = 1'b0;
        capture = 1'b0;
        unique case (1'b1)
            (state == IDLE): begin
                if (bus.req_valid) begin
                    accept  = 1'b1;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            (state == RUN): begin
                if (slot_free) begin
                    capture = 1'b1;
                    // terminal value is an explicit compare, so odd widths stop at width-1
                    if (at_last) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt + sw'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.sh_bits <= '0;
            bus.sh_dir  <= 1'b0;
        end else if (accept) begin
            bus.sh_bits <= bus.req_bits;
            bus.sh_dir  <= bus.req_dir;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.out_valid <= 1'b0;
            bus.out_bits  <= '0;
            bus.out_shift <= '0;
            bus.out_last  <= 1'b0;
        end else if (capture) begin
            bus.out_valid <= 1'b1;
            bus.out_bits  <= bus.sh_res;
            bus.out_shift <= cnt;
            bus.out_last  <= at_last;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_lr_shift_sweep.sv
// Bench for lr_shift_sweep: table vectors, corner sequences and a
// randomized run scored against a per-request sweep model.
module tb_lr_shift_sweep;
    logic clk;
    logic rst;
    int   cyc;
    int   total;
    int   bad;

    lr_shift_sweep_if #(.width(8)) bus ();

    lr_shift_sweep #(.width(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // flat shifter the sequencer is paired with
    assign bus.sh_res = bus.sh_dir ? (bus.sh_bits >> bus.sh_shift)
                                   : (bus.sh_bits << bus.sh_shift);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] b;
        logic [2:0] s;
        logic       l;
        int         t;
    } res_t;

    typedef struct {
        logic [7:0] b;
        logic       d;
        logic [7:0] e [8];
    } vec_t;

    res_t got[$];
    res_t exp_q[$];
    vec_t vt[4];
    bit   rnd_en;

    // every consumed result, sampled where the next edge will see it
    always @(negedge clk) begin
        if (rst && bus.out_valid && bus.out_ready) begin
            res_t r;
            r.b = bus.out_bits;
            r.s = bus.out_shift;
            r.l = bus.out_last;
            r.t = cyc;
            got.push_back(r);
        end
    end

    function automatic void add_sweep(logic [7:0] b, logic d);
        for (int s = 0; s < 8; s++) begin
            res_t r;
            r.b = d ? 8'(b >> s) : 8'(b << s);
            r.s = 3'(s);
            r.l = (s == 7);
            r.t = 0;
            exp_q.push_back(r);
        end
    endfunction

    always @(negedge clk) begin
        if (rnd_en && rst && bus.req_valid && bus.req_ready)
            add_sweep(bus.req_bits, bus.req_dir);
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic send(logic [7:0] b, logic d, output int acc);
        int c;
        bus.req_valid = 1'b1;
        bus.req_bits  = b;
        bus.req_dir   = d;
        for (c = 0; c < 50; c++) begin
            @(negedge clk);
            if (bus.req_ready) break;
        end
        check("accept", 32'(c < 50), 32'd1);
        @(posedge clk);
        #1;
        acc = cyc;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_n(int n);
        for (int c = 0; c < 300 && got.size() < n; c++) @(posedge clk);
        #1;
        check("count", got.size(), n);
    endtask

    task automatic drain(string name);
        int n;
        check("count", got.size(), exp_q.size());
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int k = 0; k < n; k++)
            check(name, {got[k].b, got[k].s, got[k].l},
                        {exp_q[k].b, exp_q[k].s, exp_q[k].l});
        got.delete();
        exp_q.delete();
    endtask

    task automatic apply_vec(int i);
        int acc;
        int busy;
        got.delete();
        bus.out_ready = 1'b1;
        send(vt[i].b, vt[i].d, acc);
        if (i == 1) begin
            busy = 0;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if (bus.req_ready) break;
                busy++;
            end
            check("busy_cycles", busy, 8);
            @(posedge clk);
            #1;
        end
        wait_n(8);
        if (got.size() >= 8) begin
            check("latency", got[0].t - acc, 1);
            check("consecutive", got[7].t - got[0].t, 7);
            for (int k = 0; k < 8; k++) begin
                check("vec_bits", got[k].b, vt[i].e[k]);
                check("vec_shift", got[k].s, k);
                check("vec_last", got[k].l, 32'(k == 7));
            end
        end
        got.delete();
    endtask

    initial begin
        int acc;
        int a1;
        int a2;
        int lasts;
        int c;

        total = 0;
        bad   = 0;
        rnd_en = 1'b0;
        vt[0] = '{b: 8'h81, d: 1'b0,
                  e: '{8'h81, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80}};
        vt[1] = '{b: 8'h81, d: 1'b1,
                  e: '{8'h81, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01}};
        vt[2] = '{b: 8'h3C, d: 1'b1,
                  e: '{8'h3C, 8'h1E, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00, 8'h00}};
        vt[3] = '{b: 8'h0F, d: 1'b0,
                  e: '{8'h0F, 8'h1E, 8'h3C, 8'h78, 8'hF0, 8'hE0, 8'hC0, 8'h80}};

        bus.req_valid = 1'b0;
        bus.req_bits  = '0;
        bus.req_dir   = 1'b0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        #2 rst = 1'b0;

        @(negedge clk);
        check("rst_req_ready", bus.req_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_bits", bus.out_bits, 0);
        check("rst_out_shift", bus.out_shift, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_sh_bits", bus.sh_bits, 0);
        check("rst_sh_dir", bus.sh_dir, 0);
        @(posedge clk);
        #1 rst = 1'b1;

        for (int i = 0; i < 3; i++) apply_vec(i);

        // backpressure while the second result is presented
        bus.out_ready = 1'b1;
        got.delete();
        send(8'hFF, 1'b0, acc);
        for (c = 0; c < 20; c++) begin
            if (bus.out_valid && bus.out_shift == 3'd1) break;
            @(posedge clk);
            #1;
        end
        check("stall_reach", 32'(c < 20), 1);
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_bits", bus.out_bits, 8'hFE);
            check("stall_valid", bus.out_valid, 1);
            check("stall_sh_shift", bus.sh_shift, 2);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        add_sweep(8'hFF, 1'b0);
        wait_n(8);
        drain("stall_seq");

        // back-to-back requests with req_valid held
        bus.req_valid = 1'b1;
        bus.req_bits  = 8'h01;
        bus.req_dir   = 1'b0;
        for (c = 0; c < 30; c++) begin
            @(negedge clk);
            if (bus.req_ready) break;
        end
        @(posedge clk);
        #1;
        a1 = cyc;
        bus.req_bits = 8'h80;
        bus.req_dir  = 1'b1;
        for (c = 0; c < 30; c++) begin
            @(negedge clk);
            if (bus.req_ready) break;
        end
        @(posedge clk);
        #1;
        a2 = cyc;
        bus.req_valid = 1'b0;
        check("b2b_spacing", a2 - a1, 9);
        add_sweep(8'h01, 1'b0);
        add_sweep(8'h80, 1'b1);
        wait_n(16);
        lasts = 0;
        foreach (got[k]) if (got[k].l) lasts++;
        check("b2b_lasts", lasts, 2);
        drain("b2b_seq");

        // reset during the fourth result
        send(8'h33, 1'b0, acc);
        for (c = 0; c < 20; c++) begin
            if (bus.out_valid && bus.out_shift == 3'd3) break;
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        #1;
        check("mid_rst_valid", bus.out_valid, 0);
        check("mid_rst_ready", bus.req_ready, 1);
        check("mid_rst_bits", bus.out_bits, 0);
        @(negedge clk);
        rst = 1'b1;
        got.delete();
        exp_q.delete();
        @(posedge clk);
        #1;
        apply_vec(3);

        // request pulsed during a sweep is ignored
        send(8'hA5, 1'b0, acc);
        bus.req_valid = 1'b1;
        bus.req_bits  = 8'h3C;
        bus.req_dir   = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("run_req_ready", bus.req_ready, 0);
            check("run_sh_bits", bus.sh_bits, 8'hA5);
            check("run_sh_dir", bus.sh_dir, 0);
            @(posedge clk);
            #1;
        end
        bus.req_valid = 1'b0;
        add_sweep(8'hA5, 1'b0);
        wait_n(8);
        drain("ignore_seq");
        check("idle_sh_bits", bus.sh_bits, 8'hA5);

        // randomized traffic with random backpressure
        rnd_en = 1'b1;
        for (int k = 0; k < 800; k++) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.req_valid = ($urandom_range(0, 3) == 0);
            bus.req_bits  = 8'($urandom);
            bus.req_dir   = 1'($urandom);
            @(posedge clk);
            #1;
        end
        bus.req_valid = 1'b0;
        bus.out_ready = 1'b1;
        rnd_en = 1'b0;
        for (c = 0; c < 300 && got.size() < exp_q.size(); c++) @(posedge clk);
        #1;
        drain("rand_seq");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
